tdm_demux_1x8: RTL and testbench



---
 rtl/tdm_demux_1x8.sv | 84 ++++++++
 tb/tb_tdm_demux_1x8.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1x8.sv
// 1-to-8 time-division demultiplexer: steers serialized slot samples into a registered 8-channel word.
// Optional mid-frame sync detection is enabled with `define TDM_DEMUX_SYNC_ERR_EN.
module tdm_demux_1x8 #(
  parameter int unsigned W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic           vld,
  input  logic           sync,
  output logic [2:0]     s,
  output logic [8*W-1:0] y,
  output logic           done,
  output logic           sync_err
);

  logic [2:0]     cnt_q, cnt_d;
  logic [7*W-1:0] sh_q, sh_d;
  logic [8*W-1:0] y_q, y_d;
  logic           done_q, done_d;
  logic [2:0]     eslot;

  assign eslot = sync ? 3'd0 : cnt_q;

  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    y_d    = y_q;
    done_d = 1'b0;
    if (vld) begin
      // A sync starts a fresh frame, so nothing from an aborted one can reach y.
      if (sync) begin
        sh_d = '0;
      end
      for (int unsigned k = 0; k < 7; k++) begin
        if (eslot == 3'(k)) begin
          sh_d[k*W +: W] = din;
        end
      end
      cnt_d = eslot + 3'd1;
      if (eslot == 3'd7) begin
        y_d    = {din, sh_q};
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 3'd0;
      sh_q   <= '0;
      y_q    <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      y_q    <= y_d;
      done_q <= done_d;
    end
  end

`ifdef TDM_DEMUX_SYNC_ERR_EN
  logic sync_err_q, sync_err_d;

  assign sync_err_d = vld && sync && (cnt_q != 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= sync_err_d;
    end
  end

  assign sync_err = sync_err_q;
`else
  assign sync_err = 1'b0;
`endif

  assign s    = cnt_q;
  assign y    = y_q;
  assign done = done_q;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Directed bench for tdm_demux_1x8: W=1 instance for framing/realign/reset, W=4 instance for width.
module tb_tdm_demux_1x8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       din, vld, sync;
  logic [2:0] s;
  logic [7:0] y;
  logic       done, sync_err;

  logic [3:0]  din4;
  logic        vld4, sync4;
  logic [2:0]  s4;
  logic [31:0] y4;
  logic        done4, sync_err4;

  int total = 0;
  int bad   = 0;
  logic [7:0] last_y;
  logic       se_exp;

  tdm_demux_1x8 #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .vld(vld), .sync(sync),
    .s(s), .y(y), .done(done), .sync_err(sync_err)
  );

  tdm_demux_1x8 #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .vld(vld4), .sync(sync4),
    .s(s4), .y(y4), .done(done4), .sync_err(sync_err4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic acc(input logic sy, input logic d);
    vld  = 1'b1;
    sync = sy;
    din  = d;
    @(posedge clk);
    #1;
    vld  = 1'b0;
    sync = 1'b0;
  endtask

  task automatic idle();
    vld  = 1'b0;
    sync = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Slot k carries bit k of f, so y must equal f at completion.
  task automatic send_frame(input logic [7:0] f, input logic use_sync, input logic exp_err);
    for (int k = 0; k < 8; k++) begin
      acc(use_sync && (k == 0), f[k]);
      chk("s_seq", 32'(s), 32'((k + 1) % 8));
      if (k < 7) begin
        chk("done_low", 32'(done), 32'(0));
        chk("y_hold", 32'(y), 32'(last_y));
      end
      if (k == 0) chk("sync_err", 32'(sync_err), 32'(exp_err));
      if (k == 1) chk("sync_err_clr", 32'(sync_err), 32'(0));
    end
    chk("y_frame", 32'(y), 32'(f));
    chk("done_pulse", 32'(done), 32'(1));
    last_y = f;
  endtask

  initial begin
`ifdef TDM_DEMUX_SYNC_ERR_EN
    se_exp = 1'b1;
`else
    se_exp = 1'b0;
`endif
    rst_n = 1'b0;
    din = 1'b0; vld = 1'b0; sync = 1'b0;
    din4 = 4'h0; vld4 = 1'b0; sync4 = 1'b0;
    last_y = 8'h00;
    #1;
    chk("rst_y", 32'(y), 32'(0));
    chk("rst_s", 32'(s), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sync_err", 32'(sync_err), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // 1: aligned frame 0x4D
    send_frame(8'h4D, 1'b1, 1'b0);
    idle();
    chk("t1_done_single", 32'(done), 32'(0));
    chk("t1_y_stable", 32'(y), 32'(8'h4D));

    // 2: same frame with bubbles after slots 2 and 5
    for (int k = 0; k < 8; k++) begin
      acc(k == 0, 1'((8'h4D >> k) & 8'h01));
      chk("t2_s", 32'(s), 32'((k + 1) % 8));
      if (k == 2 || k == 5) begin
        idle();
        chk("t2_s_hold", 32'(s), 32'(k + 1));
        chk("t2_done_bubble", 32'(done), 32'(0));
      end
      if (k < 7) chk("t2_done_low", 32'(done), 32'(0));
    end
    chk("t2_y", 32'(y), 32'(8'h4D));
    chk("t2_done", 32'(done), 32'(1));
    idle();
    chk("t2_done_single", 32'(done), 32'(0));

    // 3: back-to-back frames, sync only on the first
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    idle();
    chk("t3_done_single", 32'(done), 32'(0));

    // 4: partial 0xFF aborted by realigning sync, then 0x01
    for (int k = 0; k < 5; k++) begin
      acc(k == 0, 1'b1);
    end
    chk("t4_s_partial", 32'(s), 32'(5));
    chk("t4_y_hold", 32'(y), 32'(8'h3C));
    send_frame(8'h01, 1'b1, se_exp);
    idle();

    // 5: asynchronous reset between clock edges at slot 4
    for (int k = 0; k < 4; k++) begin
      acc(k == 0, 1'b1);
    end
    chk("t5_s_pre", 32'(s), 32'(4));
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_y", 32'(y), 32'(0));
    chk("t5_rst_s", 32'(s), 32'(0));
    chk("t5_rst_done", 32'(done), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    last_y = 8'h00;
    send_frame(8'h81, 1'b0, 1'b0);
    idle();

    // 6: W=4 instance, sync with vld=0 mid-stream must be ignored
    chk("t6_y4_init", y4, 32'h0);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        vld4 = 1'b0; sync4 = 1'b1; din4 = 4'hF;
        @(posedge clk);
        #1;
        chk("t6_s4_ignore", 32'(s4), 32'(4));
        chk("t6_y4_hold", y4, 32'h0);
      end
      vld4 = 1'b1; sync4 = (k == 0); din4 = 4'(k);
      @(posedge clk);
      #1;
      vld4 = 1'b0; sync4 = 1'b0;
      chk("t6_s4", 32'(s4), 32'((k + 1) % 8));
    end
    chk("t6_y4", y4, 32'h7654_3210);
    chk("t6_done4", 32'(done4), 32'(1));
    chk("t6_sync_err4", 32'(sync_err4), 32'(0));
    @(posedge clk);
    #1;
    chk("t6_done4_single", 32'(done4), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
